// File: rtl/sigma_delta_i2s_tx.sv
// sigma_delta_i2s_tx
// Buffers signed ADC samples in a small FIFO and serialises them as an I2S
// stream. Each frame carries one sample, duplicated into the left and right
// slots. Bits go MSB first and start one BCLK after the word-select change.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : asynchronous active-low reset
//   sample_in    : signed sample, SAMPLE_BITLEN bits
//   sample_valid : one-clk write strobe for sample_in
//   i2s_bclk     : serial bit clock
//   i2s_lrclk    : word select, 0 = left slot, 1 = right slot
//   i2s_sdata    : serial data
//   fifo_level   : current FIFO occupancy
//   overflow     : one-clk pulse when a write is dropped on a full FIFO
//   underrun     : one-clk pulse when a frame starts with the FIFO empty
module sigma_delta_i2s_tx #(
    parameter int SAMPLE_BITLEN = 16,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SAMPLE_BITLEN-1:0]         sample_in,
    input  logic                             sample_valid,
    output logic                             i2s_bclk,
    output logic                             i2s_lrclk,
    output logic                             i2s_sdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             overflow,
    output logic                             underrun
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(2 * SLOT_BITS);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [NW-1:0] N_LAST   = NW'(2 * SLOT_BITS - 1);
    localparam logic [NW-1:0] N_SLOT   = NW'(SLOT_BITS);
    localparam logic [NW-1:0] N_SAMPLE = NW'(SAMPLE_BITLEN);
    localparam logic [NW-1:0] N_ZERO   = NW'(0);
    localparam logic [NW-1:0] N_ONE    = NW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_r;
    logic [DW-1:0]             div_r;
    logic [NW-1:0]             n_r;
    logic                      bclk_r;
    logic                      lrclk_r;
    logic                      sdata_r;
    logic                      overflow_r;
    logic                      underrun_r;
    logic [SAMPLE_BITLEN-1:0]  frame_r;
    logic [SAMPLE_BITLEN-1:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_r;
    logic [AW-1:0]             rd_ptr_r;
    logic [LW-1:0]             level_r;

    logic                      tick_s;
    logic                      fall_s;
    logic [NW-1:0]             n_inc_s;
    logic                      frame_start_s;
    logic                      pop_s;
    logic                      push_s;
    logic                      drop_s;
    logic [SAMPLE_BITLEN-1:0]  frame_s;
    logic [NW-1:0]             slot_pos_s;
    logic [SAMPLE_BITLEN-1:0]  shifted_s;
    logic                      sdata_s;

    // Next-cycle control: bit clock ticks, frame boundaries, FIFO handshakes and the next data bit.
    always_comb begin
        tick_s        = 1'b0;
        fall_s        = 1'b0;
        n_inc_s       = N_ZERO;
        frame_start_s = 1'b0;
        pop_s         = 1'b0;
        push_s        = 1'b0;
        drop_s        = 1'b0;
        frame_s       = frame_r;
        slot_pos_s    = N_ZERO;
        shifted_s     = frame_r;
        sdata_s       = 1'b0;

        tick_s = (state_r == RUN) && (div_r == DIV_LAST);
        fall_s = tick_s && bclk_r;

        if (n_r == N_LAST) begin
            n_inc_s = N_ZERO;
        end else begin
            n_inc_s = n_r + N_ONE;
        end

        // A frame starts either on leaving IDLE or when n wraps back to 0.
        if (state_r == IDLE) begin
            frame_start_s = (level_r != LVL_ZERO);
        end else begin
            frame_start_s = fall_s && (n_inc_s == N_ZERO);
        end

        pop_s  = frame_start_s && (level_r != LVL_ZERO);
        // A same-cycle pop frees a slot, so a write to a full FIFO still lands.
        push_s = sample_valid && ((level_r != LVL_FULL) || pop_s);
        drop_s = sample_valid && (level_r == LVL_FULL) && !pop_s;

        if (pop_s) begin
            frame_s = mem_r[rd_ptr_r];
        end else begin
            frame_s = frame_r;
        end

        if (n_inc_s >= N_SLOT) begin
            slot_pos_s = n_inc_s - N_SLOT;
        end else begin
            slot_pos_s = n_inc_s;
        end

        // Slot position p selects frame bit SAMPLE_BITLEN-p: shift it up to the MSB.
        if ((slot_pos_s != N_ZERO) && (slot_pos_s <= N_SAMPLE)) begin
            shifted_s = frame_s << (slot_pos_s - N_ONE);
            sdata_s   = shifted_s[SAMPLE_BITLEN-1];
        end else begin
            shifted_s = frame_s;
            sdata_s   = 1'b0;
        end
    end

    // Serialiser state machine: owns the bit clock, bit counter, frame register and serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            div_r      <= DIV_ZERO;
            n_r        <= N_ZERO;
            bclk_r     <= 1'b0;
            lrclk_r    <= 1'b0;
            sdata_r    <= 1'b0;
            frame_r    <= '0;
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            overflow_r <= drop_s;
            underrun_r <= frame_start_s && (level_r == LVL_ZERO);
            if (pop_s) begin
                frame_r <= frame_s;
            end
            case (state_r)
                IDLE: begin
                    div_r   <= DIV_ZERO;
                    n_r     <= N_ZERO;
                    bclk_r  <= 1'b0;
                    lrclk_r <= 1'b0;
                    sdata_r <= 1'b0;
                    if (frame_start_s) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (tick_s) begin
                        div_r  <= DIV_ZERO;
                        bclk_r <= ~bclk_r;
                    end else begin
                        div_r  <= div_r + DIV_ONE;
                    end
                    // lrclk and sdata only move on the bclk falling edge.
                    if (fall_s) begin
                        n_r     <= n_inc_s;
                        lrclk_r <= (n_inc_s >= N_SLOT);
                        sdata_r <= sdata_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    div_r   <= DIV_ZERO;
                    n_r     <= N_ZERO;
                    bclk_r  <= 1'b0;
                    lrclk_r <= 1'b0;
                    sdata_r <= 1'b0;
                end
            endcase
        end
    end

    // Sample FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= LVL_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= sample_in;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign i2s_bclk   = bclk_r;
    assign i2s_lrclk  = lrclk_r;
    assign i2s_sdata  = sdata_r;
    assign fifo_level = level_r;
    assign overflow   = overflow_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_sigma_delta_i2s_tx.sv
// Directed bench for sigma_delta_i2s_tx at default parameters (256-clk frames, bit n held for clks 4n..4n+3).
module tb_sigma_delta_i2s_tx;

    logic        clk;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        underrun;

    int n_asserts;
    int n_fail;

    sigma_delta_i2s_tx dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected 64-bit frame: index n holds the bit sent in bit period n.
    function automatic logic [63:0] exp_frame(input logic [15:0] s);
        logic [63:0] v;
        int p;
        v = 64'd0;
        for (int k = 0; k < 64; k++) begin
            p = k % 32;
            if (p >= 1 && p <= 16) v[k] = s[16-p];
        end
        return v;
    endfunction

    function automatic logic [15:0] ramp(input int i);
        return 16'h1000 + 16'(i * 16'h0123);
    endfunction

    // Called just after a frame-start edge; returns just after the next one.
    // Writes wv[0..wr_n-1] land on edges wr_at.. relative to this frame start.
    task automatic capture(input string tag, input logic [15:0] exp_s, input logic exp_ur,
                           input int exp_lvl0, input int wr_at, input int wr_n,
                           input logic [4:0][15:0] wv, input int exp_ovf, output int max_lvl);
        logic [63:0] bits;
        logic [63:0] lrs;
        int ovf;
        int ur_extra;
        int bclk_err;
        int j;
        bits = 64'd0; lrs = 64'd0; ovf = 0; ur_extra = 0; bclk_err = 0; max_lvl = 0;
        check({tag, " underrun@start"}, 64'(underrun), 64'(exp_ur));
        check({tag, " level@start"}, 64'(fifo_level), 64'(exp_lvl0));
        for (int c = 0; c < 256; c++) begin
            if (c > 0 && underrun) ur_extra++;
            if (overflow) ovf++;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (i2s_bclk !== ((c % 4) >= 2)) bclk_err++;
            if (c % 4 == 2) begin
                bits[c/4] = i2s_sdata;
                lrs[c/4]  = i2s_lrclk;
            end
            if (wr_n > 0 && c >= wr_at && c < wr_at + wr_n) begin
                j = c - wr_at;
                check({tag, " level after write"}, 64'(fifo_level), 64'((j + 1 > 4) ? 4 : j + 1));
                check({tag, " overflow after write"}, 64'(overflow), 64'(j == 4));
            end
            if (wr_n > 0 && c + 1 >= wr_at && c + 1 < wr_at + wr_n) begin
                sample_valid = 1'b1;
                sample_in    = wv[3'(c + 1 - wr_at)];
            end else begin
                sample_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        check({tag, " sdata bits"}, bits, exp_frame(exp_s));
        check({tag, " lrclk bits"}, lrs, 64'hFFFF_FFFF_0000_0000);
        check({tag, " overflow count"}, 64'(ovf), 64'(exp_ovf));
        check({tag, " extra underruns"}, 64'(ur_extra), 64'd0);
        check({tag, " bclk shape errors"}, 64'(bclk_err), 64'd0);
    endtask

    initial begin
        int zero_err;
        int mx;
        logic [4:0][15:0] none;
        logic [4:0][15:0] ae;
        logic [4:0][15:0] one;
        n_asserts = 0; n_fail = 0;
        none = '0;
        ae   = {16'h0EEE, 16'hD00D, 16'hC3C3, 16'hB00B, 16'hA55A};
        rst = 1'b0; sample_valid = 1'b0; sample_in = 16'h0000;

        // Reset state before any clock edge.
        #1;
        check("reset outputs", {58'd0, i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun, 1'b0}, 64'd0);
        check("reset level", 64'(fifo_level), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;

        // Idle for 2000 clks without writes: everything stays 0.
        zero_err = 0;
        repeat (2000) begin
            @(posedge clk); #1;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun} !== 5'd0 || fifo_level !== 3'd0)
                zero_err++;
        end
        check("idle 2000 clks nonzero count", 64'(zero_err), 64'd0);

        // Single write of 0x8001 starts RUN on the following clk.
        sample_valid = 1'b1; sample_in = 16'h8001;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check("level after first write", 64'(fifo_level), 64'd1);
        check("bclk still idle", 64'(i2s_bclk), 64'd0);
        @(posedge clk); #1;
        capture("first 8001", 16'h8001, 1'b0, 0, -1, 0, none, 0, mx);

        // No more writes: underrun each frame and 0x8001 repeats.
        capture("repeat1 8001", 16'h8001, 1'b1, 0, -1, 0, none, 0, mx);
        capture("repeat2 8001", 16'h8001, 1'b1, 0, -1, 0, none, 0, mx);

        // Five back-to-back writes mid-frame: E is dropped, A..D follow in order.
        capture("burst frame", 16'h8001, 1'b1, 0, 100, 5, ae, 1, mx);
        capture("frame A", 16'hA55A, 1'b0, 3, -1, 0, none, 0, mx);
        capture("frame B", 16'hB00B, 1'b0, 2, -1, 0, none, 0, mx);
        capture("frame C", 16'hC3C3, 1'b0, 1, -1, 0, none, 0, mx);
        capture("frame D", 16'hD00D, 1'b0, 0, -1, 0, none, 0, mx);

        // D is reused, not E: at n=33 the right slot shows D's MSB.
        check("underrun after D", 64'(underrun), 64'd1);
        repeat (134) @(posedge clk);
        #1;
        check("pre-reset bclk/lrclk/sdata", {61'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 64'd7);

        // Asynchronous reset mid-slot, checked between clock edges.
        #2 rst = 1'b0;
        #1;
        check("async reset outputs", {59'd0, i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun}, 64'd0);
        check("async reset level", 64'(fifo_level), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        sample_valid = 1'b1; sample_in = 16'h1234;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        check("level after restart write", 64'(fifo_level), 64'd1);
        @(posedge clk); #1;
        one = '0; one[0] = ramp(0);
        capture("restart 1234", 16'h1234, 1'b0, 0, 50, 1, one, 0, mx);

        // One write per frame for 100 frames: ramp arrives in order, level stays <= 1.
        for (int i = 0; i < 100; i++) begin
            one = '0; one[0] = ramp(i + 1);
            capture($sformatf("ramp %0d", i), ramp(i), 1'b0, 0, (i < 99) ? 50 : -1,
                    (i < 99) ? 1 : 0, one, 0, mx);
            check($sformatf("ramp %0d max level", i), 64'(mx <= 1), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/sigma_delta_i2s_tx.md
SIGMA_DELTA_I2S_TX -- requirements
Module: sigma_delta_i2s_tx

Interface
REQ-001 SHALL have parameter SAMPLE_BITLEN, default 16, width of the signed input sample; legal range 2 to SLOT_BITS-1.
REQ-002 SHALL have parameter SLOT_BITS, default 32, BCLK periods per channel slot.
REQ-003 SHALL have parameter BCLK_DIV, default 2, clk cycles per BCLK half-period; legal values are 1 and above.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, sample FIFO entries; legal values are powers of 2 from 2 upward.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port sample_in, input, SAMPLE_BITLEN bits: signed sample from the ADC signed output.
REQ-008 SHALL have port sample_valid, input, 1 bit: one-clk write strobe for sample_in.
REQ-009 SHALL have port i2s_bclk, output, 1 bit: serial bit clock.
REQ-010 SHALL have port i2s_lrclk, output, 1 bit: word select, 0 = left slot, 1 = right slot.
REQ-011 SHALL have port i2s_sdata, output, 1 bit: serial data.
REQ-012 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH+1) bits: current FIFO occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: one-clk pulse when a write is dropped.
REQ-014 SHALL have port underrun, output, 1 bit: one-clk pulse when a frame starts with the FIFO empty.

Function
REQ-015 SHALL buffer samples in a FIFO; a write occurs in any clk where sample_valid=1 and the FIFO is not full after any same-cycle pop.
REQ-016 SHALL, on a write with the FIFO full and no same-cycle pop, discard sample_in, leave FIFO contents unchanged, and pulse overflow for one clk.
REQ-017 SHALL allow a simultaneous pop and write when full (level unchanged) and when empty (underrun applies; the write is stored; there is no bypass).
REQ-018 SHALL implement two states, IDLE and RUN; in IDLE, bclk, lrclk and sdata are held at 0.
REQ-019 SHALL go IDLE->RUN on the first clk where fifo_level is not 0; RUN is left only by reset.
REQ-020 SHALL, on the IDLE->RUN clk, perform a frame start: set bit counter n=0, div counter=0, bclk=0.
REQ-021 SHALL, in RUN, toggle bclk every BCLK_DIV clks; each bclk falling edge advances n modulo 2*SLOT_BITS. One bit lasts 2*BCLK_DIV clks; a frame lasts 4*SLOT_BITS*BCLK_DIV clks (256 at defaults).
REQ-022 SHALL treat n wrapping to 0 as a frame start: pop the FIFO head into the frame register; if the FIFO is empty, reuse the frame register and pulse underrun for one clk.
REQ-023 SHALL update lrclk and sdata only on falling-edge clks (and on the frame-start clk); lrclk = (n >= SLOT_BITS).
REQ-024 SHALL drive sdata, with slot position p = n mod SLOT_BITS: p=0 gives 0; p=1..SAMPLE_BITLEN gives frame_reg[SAMPLE_BITLEN-p] (MSB first, one bit after the lrclk change); other p gives 0.
REQ-025 SHALL transmit the same sample in the left and right slots (mono duplicate).
REQ-026 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while rst=0, asynchronously force: state IDLE, FIFO empty, fifo_level 0, frame register 0, counters 0, all outputs 0.
REQ-028 SHALL discard any partially transmitted frame on reset; after release, operation restarts from IDLE per REQ-019.

Verification
REQ-029 SHALL check: reset then no sample_valid for 2000 clks -> bclk, lrclk, sdata, fifo_level, overflow and underrun all remain 0.
REQ-030 SHALL check: a single write of 0x8001 at defaults -> RUN entered, fifo_level returns to 0; at n=1 and n=16 sdata=1, n=2..15 and 17..31 give 0; the right slot (n=33..48) repeats the pattern.
REQ-031 SHALL check: after REQ-030, no further writes -> underrun pulses exactly once per 256 clks and 0x8001 is retransmitted each frame.
REQ-032 SHALL check: in RUN mid-frame with the FIFO empty, 5 consecutive-clk writes A..E -> level reaches 4, overflow pulses on the E clk, and E is never transmitted; the next 4 frames carry A, B, C, D in order.
REQ-033 SHALL check: rst asserted mid-slot -> all outputs 0 without waiting for a clk edge; after release with one write, the first frame restarts at n=0.
REQ-034 SHALL check: sample_valid every 256 clks for 100 frames with a ramp of values -> no overflow or underrun, fifo_level never exceeds 1, and the ramp is received in order.
